// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and constants for the MIDI voice allocator
package midi_pkg;

  // Wide enough for the saturating age of the largest (16-voice) configuration.
  localparam int AGE_W = 5;

  localparam logic NOTE_ON  = 1'b1;
  localparam logic NOTE_OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    COLLECTING,
    TRANSMIT
  } burst_state_t;

  typedef struct packed {
    logic [7:0]       note;
    logic [7:0]       velocity;
    logic [3:0]       channel;
    logic             active;
    logic [AGE_W-1:0] age;
  } voice_t;

endpackage

// File: rtl/midi_slot_select.sv
// rtl/midi_slot_select.sv - combinational slot match, first-free and oldest-slot search
module midi_slot_select
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 5
) (
  input  logic [NUM_VOICES-1:0][7:0]       slot_note_i,
  input  logic [NUM_VOICES-1:0][3:0]       slot_chan_i,
  input  logic [NUM_VOICES-1:0]            slot_active_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] slot_age_i,
  input  logic [7:0]                       note_i,
  input  logic [3:0]                       chan_i,
  output logic [NUM_VOICES-1:0]            match_o,
  output logic [$clog2(NUM_VOICES)-1:0]    free_idx_o,
  output logic                             free_valid_o,
  output logic [$clog2(NUM_VOICES)-1:0]    oldest_idx_o
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic             free_found;
  logic             old_found;
  logic [AGE_W-1:0] best_age;

  // Strict '>' keeps the lowest index when ages tie.
  always_comb begin
    match_o      = '0;
    free_found   = 1'b0;
    free_idx_o   = '0;
    old_found    = 1'b0;
    best_age     = '0;
    oldest_idx_o = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_o[i] = slot_active_i[i] && (slot_note_i[i] == note_i) && (slot_chan_i[i] == chan_i);
      if (!slot_active_i[i] && !free_found) begin
        free_found = 1'b1;
        free_idx_o = IDX_W'(i);
      end
      if (slot_active_i[i] && (!old_found || (slot_age_i[i] > best_age))) begin
        old_found    = 1'b1;
        best_age     = slot_age_i[i];
        oldest_idx_o = IDX_W'(i);
      end
    end
    free_valid_o = free_found;
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// rtl/midi_voice_alloc.sv - polyphonic voice allocator with burst snapshot strobe
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int          NUM_VOICES     = 5,
  parameter int          BURST_DURATION = 500_000,
  parameter logic [15:0] CHANNEL_MASK   = 16'hFFFF,
  parameter bit          STEAL_OLDEST   = 1'b1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [7:0]                  midi_velocity_in,
  input  logic [7:0]                  midi_received_note_in,
  input  logic [3:0]                  midi_channel_in,
  input  logic                        midi_status_in,
  input  logic                        midi_data_ready_in,
  input  logic                        all_notes_off_in,
  output logic [NUM_VOICES-1:0][15:0] burst_notes_out,
  output logic [NUM_VOICES-1:0][3:0]  voice_channel_out,
  output logic [NUM_VOICES-1:0]       note_on_out,
  output logic                        burst_refresh_out,
  output logic                        dropped_out
);

  localparam int               IDX_W    = $clog2(NUM_VOICES);
  localparam int               CYC_W    = $clog2(BURST_DURATION) + 1;
  localparam int               CNT_W    = $clog2(NUM_VOICES) + 1;
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'((1 << (IDX_W + 1)) - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BURST_DURATION - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_VOICES);

  voice_t [NUM_VOICES-1:0] slots_q, slots_d;
  burst_state_t            state_q, state_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dropped_q, dropped_d;

  logic [NUM_VOICES-1:0][7:0]       slot_note;
  logic [NUM_VOICES-1:0][3:0]       slot_chan;
  logic [NUM_VOICES-1:0]            slot_active;
  logic [NUM_VOICES-1:0][AGE_W-1:0] slot_age;
  logic [NUM_VOICES-1:0]            match;
  logic [IDX_W-1:0]                 free_idx, oldest_idx, target;
  logic                             free_valid, accept, is_off;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      slot_note[i]   = slots_q[i].note;
      slot_chan[i]   = slots_q[i].channel;
      slot_active[i] = slots_q[i].active;
      slot_age[i]    = slots_q[i].age;
    end
  end

  midi_slot_select #(.NUM_VOICES(NUM_VOICES)) u_select (
    .slot_note_i   (slot_note),
    .slot_chan_i   (slot_chan),
    .slot_active_i (slot_active),
    .slot_age_i    (slot_age),
    .note_i        (midi_received_note_in),
    .chan_i        (midi_channel_in),
    .match_o       (match),
    .free_idx_o    (free_idx),
    .free_valid_o  (free_valid),
    .oldest_idx_o  (oldest_idx)
  );

  assign accept = midi_data_ready_in && CHANNEL_MASK[midi_channel_in] && !all_notes_off_in;
  assign is_off = (midi_status_in == NOTE_OFF) || (midi_velocity_in == 8'd0);
  assign target = free_valid ? free_idx : oldest_idx;

  always_comb begin
    slots_d   = slots_q;
    dropped_d = 1'b0;
    if (all_notes_off_in) begin
      slots_d = '0;
    end else if (accept) begin
      if (is_off) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (match[i]) slots_d[i] = '0;
      end else if (|match) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (match[i]) slots_d[i].velocity = midi_velocity_in;
      end else if (free_valid || STEAL_OLDEST) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == target) begin
            slots_d[i] = '{note: midi_received_note_in, velocity: midi_velocity_in,
                           channel: midi_channel_in, active: 1'b1, age: '0};
          end else if (slots_q[i].active && (slots_q[i].age != AGE_SAT)) begin
            slots_d[i].age = slots_q[i].age + 1'b1;
          end
        end
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      cnt_q     <= '0;
      slots_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      slots_q   <= slots_d;
      dropped_q <= dropped_d;
    end
  end

  // The terminating count includes a strobe arriving in this very cycle.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    if (all_notes_off_in) begin
      state_d = TRANSMIT;
      cyc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = COLLECTING;
            cnt_d   = CNT_W'(1);
            cyc_d   = '0;
          end
        end
        COLLECTING: begin
          cyc_d = cyc_q + 1'b1;
          cnt_d = cnt_q + CNT_W'(accept);
          if ((cyc_q == CYC_LAST) || (cnt_d == CNT_FULL)) begin
            state_d = TRANSMIT;
            cyc_d   = '0;
            cnt_d   = '0;
          end
        end
        TRANSMIT: begin
          state_d = accept ? COLLECTING : IDLE;
          cnt_d   = accept ? CNT_W'(1) : '0;
          cyc_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    burst_refresh_out = (state_q == TRANSMIT);
    dropped_out       = dropped_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      burst_notes_out[i]   = {slots_q[i].note, slots_q[i].velocity};
      voice_channel_out[i] = slots_q[i].channel;
      note_on_out[i]       = slots_q[i].active;
    end
  end

endmodule
